// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encoding and defaults
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4
    } spi_state_t;

    localparam int DATA_W_DEF  = 8;
    localparam int CLK_DIV_DEF = 4;

    // Slice to the select width in use; every select deasserted.
    localparam logic [31:0] SS_IDLE = '1;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period tick generator for the SPI master
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-transfer mode 0 SPI initiator
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int NUM_SS  = 2,
    parameter int SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    spi_state_t        state;
    spi_state_t        state_next;
    logic              tick;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [BIT_W-1:0]  bit_cnt;
    logic              first_high;

    // Out-of-range selects decode to all-ones so the transfer runs unseen.
    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_SS-1:0] v;
        v = SS_IDLE[NUM_SS-1:0];
        for (int i = 0; i < NUM_SS; i++) begin
            if (sel == SEL_W'(i)) begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .enable (state != IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   if (tick)  state_next = HIGH;
            HIGH:    if (tick)  state_next = (bit_cnt == '0) ? HOLD : LOW;
            LOW:     if (tick)  state_next = HIGH;
            HOLD:    if (tick)  state_next = IDLE;
            default:            state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck        <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            first_high <= 1'b0;
            ss_n       <= SS_IDLE[NUM_SS-1:0];
            done       <= 1'b0;
            rx_data    <= '0;
        end else begin
            done       <= 1'b0;
            sck        <= (state_next == HIGH);
            first_high <= (state != HIGH) && (state_next == HIGH);

            if (state == IDLE && start) begin
                tx_sr   <= tx_data;
                bit_cnt <= BIT_W'(DATA_W - 1);
                ss_n    <= ss_decode(ss_sel);
            end

            // miso is captured once per bit, at the end of the first high cycle.
            if (state == HIGH && first_high) begin
                rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end

            if (state == HIGH && tick && bit_cnt != '0) begin
                tx_sr   <= tx_sr << 1;
                bit_cnt <= bit_cnt - BIT_W'(1);
            end

            if (state == HOLD && tick) begin
                tx_sr   <= '0;
                ss_n    <= SS_IDLE[NUM_SS-1:0];
                done    <= 1'b1;
                rx_data <= rx_sr;
            end
        end
    end

    // mosi is the shift register MSB, so it only moves on LOW entry.
    assign mosi = tx_sr[DATA_W-1];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    int checks   = 0;
    int failures = 0;

    // Default build (CLK_DIV=4)
    logic       start_a = 1'b0;
    logic [0:0] ss_sel_a = 1'b0;
    logic [7:0] tx_a = 8'h00;
    logic [7:0] rx_a;
    logic       busy_a, done_a, sck_a, mosi_a, miso_a;
    logic [1:0] ss_n_a;

    // CLK_DIV=1 build
    logic       start_b = 1'b0;
    logic [0:0] ss_sel_b = 1'b0;
    logic [7:0] tx_b = 8'h00;
    logic [7:0] rx_b;
    logic       busy_b, done_b, sck_b, mosi_b, miso_b;
    logic [1:0] ss_n_b;

    spi_master u_dut_a (
        .clk     (clk1),
        .rst     (rst),
        .start   (start_a),
        .ss_sel  (ss_sel_a),
        .tx_data (tx_a),
        .rx_data (rx_a),
        .busy    (busy_a),
        .done    (done_a),
        .sck     (sck_a),
        .mosi    (mosi_a),
        .miso    (miso_a),
        .ss_n    (ss_n_a)
    );

    spi_master #(.CLK_DIV(1)) u_dut_b (
        .clk     (clk1),
        .rst     (rst),
        .start   (start_b),
        .ss_sel  (ss_sel_b),
        .tx_data (tx_b),
        .rx_data (rx_b),
        .busy    (busy_b),
        .done    (done_b),
        .sck     (sck_b),
        .mosi    (mosi_b),
        .miso    (miso_b),
        .ss_n    (ss_n_b)
    );

    // Mode 0 slave models: miso shifts after each sck fall, mosi captured on sck rise.
    logic [7:0] pat_a = 8'h00;
    logic [7:0] pat_b = 8'h00;
    int fall_a = 0, fall_b = 0;
    int low0_a = 0, low1_a = 0, rise_a = 0, mosi_bad_a = 0, done_cnt_a = 0;
    int low_b = 0, rise_b = 0, tog_b = 0, mosi_bad_b = 0, done_cnt_b = 0;
    logic prev_sck_a = 1'b0, prev_mosi_a = 1'b0;
    logic prev_sck_b = 1'b0, prev_mosi_b = 1'b0;
    logic [7:0] srx0_a = 8'h00, srx1_a = 8'h00, srx_b = 8'h00;

    assign miso_a = (fall_a < 8) ? pat_a[3'(7 - fall_a)] : 1'b0;
    assign miso_b = (fall_b < 8) ? pat_b[3'(7 - fall_b)] : 1'b0;

    always @(negedge clk1) begin
        if (!ss_n_a[0]) low0_a++;
        if (!ss_n_a[1]) low1_a++;
        if (sck_a && !prev_sck_a) begin
            rise_a++;
            if (mosi_a !== prev_mosi_a) mosi_bad_a++;
        end
        if (done_a) done_cnt_a++;
        if (ss_n_a == 2'b11) fall_a = 0;
        else if (!sck_a && prev_sck_a) fall_a++;
        prev_sck_a  = sck_a;
        prev_mosi_a = mosi_a;
    end

    always @(negedge clk1) begin
        if (ss_n_b != 2'b11) low_b++;
        if (sck_b !== prev_sck_b) tog_b++;
        if (sck_b && !prev_sck_b) begin
            rise_b++;
            if (mosi_b !== prev_mosi_b) mosi_bad_b++;
        end
        if (done_b) done_cnt_b++;
        if (ss_n_b == 2'b11) fall_b = 0;
        else if (!sck_b && prev_sck_b) fall_b++;
        prev_sck_b  = sck_b;
        prev_mosi_b = mosi_b;
    end

    always @(posedge sck_a) begin
        if (!ss_n_a[0]) srx0_a <= {srx0_a[6:0], mosi_a};
        if (!ss_n_a[1]) srx1_a <= {srx1_a[6:0], mosi_a};
    end

    always @(posedge sck_b) begin
        if (ss_n_b != 2'b11) srx_b <= {srx_b[6:0], mosi_b};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       sel;
        logic [7:0] pat;
        logic [1:0] exp_ss;
        logic [7:0] exp_rx;
        logic [7:0] exp_slave;
        int         exp_lat;
        int         exp_low;
    } vec_t;

    task automatic xfer_a(input vec_t v);
        int l0, l1, r, bad, d, lat;
        logic [7:0] srx;
        l0 = low0_a; l1 = low1_a; r = rise_a; bad = mosi_bad_a; d = done_cnt_a;
        @(negedge clk1);
        tx_a = v.tx; ss_sel_a = v.sel; pat_a = v.pat; start_a = 1'b1;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk1);
            start_a = 1'b0;
            if (k == 1) begin
                check("t1_ss_n", 32'(ss_n_a), 32'(v.exp_ss));
                check("t1_busy", 32'(busy_a), 32'd1);
                check("t1_mosi", 32'(mosi_a), 32'(v.tx[7]));
                tx_a = ~v.tx;
                ss_sel_a = ~v.sel;
            end
            if (done_a) begin
                lat = k;
                break;
            end
        end
        check("done_latency", lat, v.exp_lat);
        check("rx_data", 32'(rx_a), 32'(v.exp_rx));
        check("done_ss_idle", 32'(ss_n_a), 32'h3);
        check("done_busy", 32'(busy_a), 32'd0);
        @(negedge clk1);
        check("done_width", 32'(done_a), 32'd0);
        check("rx_hold", 32'(rx_a), 32'(v.exp_rx));
        @(negedge clk1);
        srx = v.sel ? srx1_a : srx0_a;
        check("slave_rx", 32'(srx), 32'(v.exp_slave));
        check("sel_low_cycles", v.sel ? low1_a - l1 : low0_a - l0, v.exp_low);
        check("other_low_cycles", v.sel ? low0_a - l0 : low1_a - l1, 0);
        check("sck_rises", rise_a - r, 8);
        check("mosi_stable", mosi_bad_a - bad, 0);
        check("done_count", done_cnt_a - d, 1);
    endtask

    vec_t vecs[5];

    initial begin
        int d, l0, l1, lat;

        vecs[0] = '{tx: 8'hA5, sel: 1'b0, pat: 8'h3C, exp_ss: 2'b10, exp_rx: 8'h3C, exp_slave: 8'hA5, exp_lat: 69, exp_low: 68};
        vecs[1] = '{tx: 8'h0F, sel: 1'b1, pat: 8'hC3, exp_ss: 2'b01, exp_rx: 8'hC3, exp_slave: 8'h0F, exp_lat: 69, exp_low: 68};
        vecs[2] = '{tx: 8'h00, sel: 1'b0, pat: 8'hFF, exp_ss: 2'b10, exp_rx: 8'hFF, exp_slave: 8'h00, exp_lat: 69, exp_low: 68};
        vecs[3] = '{tx: 8'hFF, sel: 1'b1, pat: 8'h00, exp_ss: 2'b01, exp_rx: 8'h00, exp_slave: 8'hFF, exp_lat: 69, exp_low: 68};
        vecs[4] = '{tx: 8'h5A, sel: 1'b0, pat: 8'h81, exp_ss: 2'b10, exp_rx: 8'h81, exp_slave: 8'h5A, exp_lat: 69, exp_low: 68};

        repeat (3) @(negedge clk1);
        rst = 1'b0;

        for (int c = 0; c < 20; c++) begin
            @(negedge clk1);
            check("idle_sck", 32'(sck_a), 32'd0);
            check("idle_ss_n", 32'(ss_n_a), 32'h3);
            check("idle_busy", 32'(busy_a), 32'd0);
            check("idle_done", 32'(done_a), 32'd0);
            check("idle_rx", 32'(rx_a), 32'd0);
        end
        check("idle_mosi", 32'(mosi_a), 32'd0);

        for (int i = 0; i < 5; i++) xfer_a(vecs[i]);

        // Back-to-back: second start issued in the done cycle of the first.
        d = done_cnt_a; l0 = low0_a; l1 = low1_a;
        @(negedge clk1);
        tx_a = 8'h0F; ss_sel_a = 1'b1; pat_a = 8'h96; start_a = 1'b1;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk1);
            start_a = 1'b0;
            if (done_a) begin
                lat = k;
                break;
            end
        end
        check("b2b_first_latency", lat, 69);
        check("b2b_first_rx", 32'(rx_a), 32'h96);
        check("b2b_gap_ss_n", 32'(ss_n_a), 32'h3);
        tx_a = 8'hF0; ss_sel_a = 1'b0; pat_a = 8'h69; start_a = 1'b1;
        @(negedge clk1);
        start_a = 1'b0;
        check("b2b_second_ss_n", 32'(ss_n_a), 32'h2);
        check("b2b_second_busy", 32'(busy_a), 32'd1);
        lat = -1;
        for (int k = 2; k <= 200; k++) begin
            @(negedge clk1);
            if (done_a) begin
                lat = k;
                break;
            end
        end
        check("b2b_second_latency", lat, 69);
        check("b2b_second_rx", 32'(rx_a), 32'h69);
        repeat (2) @(negedge clk1);
        check("b2b_slave1", 32'(srx1_a), 32'h0F);
        check("b2b_slave0", 32'(srx0_a), 32'hF0);
        check("b2b_low1", low1_a - l1, 68);
        check("b2b_low0", low0_a - l0, 68);
        check("b2b_done_count", done_cnt_a - d, 2);

        // start held high throughout a transfer with changing data and select.
        d = done_cnt_a; l1 = low1_a;
        @(negedge clk1);
        tx_a = 8'hC3; ss_sel_a = 1'b0; pat_a = 8'h5A; start_a = 1'b1;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk1);
            if (done_a) begin
                start_a = 1'b0;
                lat = k;
                break;
            end
            start_a = 1'b1;
            tx_a = 8'($urandom);
            ss_sel_a = 1'b1;
        end
        start_a = 1'b0;
        check("spam_latency", lat, 69);
        check("spam_rx", 32'(rx_a), 32'h5A);
        repeat (5) @(negedge clk1);
        check("spam_busy_after", 32'(busy_a), 32'd0);
        check("spam_done_count", done_cnt_a - d, 1);
        check("spam_slave0", 32'(srx0_a), 32'hC3);
        check("spam_low1", low1_a - l1, 0);

        // Reset in the middle of a transfer.
        d = done_cnt_a;
        @(negedge clk1);
        tx_a = 8'h33; ss_sel_a = 1'b1; pat_a = 8'hAA; start_a = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk1);
            start_a = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk1);
        rst = 1'b0;
        check("rst_ss_n", 32'(ss_n_a), 32'h3);
        check("rst_sck", 32'(sck_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_mosi", 32'(mosi_a), 32'd0);
        check("rst_rx", 32'(rx_a), 32'd0);
        repeat (100) @(negedge clk1);
        check("rst_no_done", done_cnt_a - d, 0);
        xfer_a('{tx: 8'h3C, sel: 1'b1, pat: 8'h99, exp_ss: 2'b01, exp_rx: 8'h99, exp_slave: 8'h3C, exp_lat: 69, exp_low: 68});

        // CLK_DIV=1 build.
        l0 = low_b; l1 = rise_b; d = tog_b;
        @(negedge clk1);
        tx_b = 8'h81; ss_sel_b = 1'b0; pat_b = 8'h6C; start_b = 1'b1;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk1);
            start_b = 1'b0;
            if (done_b) begin
                lat = k;
                break;
            end
        end
        check("div1_latency", lat, 18);
        check("div1_rx", 32'(rx_b), 32'h6C);
        repeat (2) @(negedge clk1);
        check("div1_low_cycles", low_b - l0, 17);
        check("div1_sck_rises", rise_b - l1, 8);
        check("div1_sck_toggles", tog_b - d, 16);
        check("div1_slave", 32'(srx_b), 32'h81);
        check("div1_mosi_stable", mosi_bad_b, 0);
        check("div1_done_count", done_cnt_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
